fault_trip_manager: RTL and testbench
=====================================

Name: fault_trip_manager

Overview:
Downstream consumer of the per-channel latched low-fault detectors (power unit). It collects their latched fault flags and drives a single trip (gate-block) output. It records the first-fault identity and runs a timed auto-retry sequence, pulsing reset_unit back into the detectors. After MAX_RETRY failed retries it locks out until the host clears it.

Parameters:
N_FAULT, 8, number of detector flags in
ID_W, 3, width of first_id (ceil log2 N_FAULT)
COOL_US, 1000, cool-down length in 1 us ticks before a retry (>=1, <=65535)
CHECK_US, 100, clean-run window in 1 us ticks after a retry (>=1, <=65535)
RST_PULSE_CLK, 4, reset_unit pulse width in clk cycles (>=1)
MAX_RETRY, 3, auto-retries before lockout (1..7)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
time_1us  in  1  1 us timebase; asynchronous to logic, synchronized internally
fault_in  in  N_FAULT  latched detector outputs, 1 = fault
fault_mask  in  N_FAULT  1 = ignore channel, applied every cycle
retry_en  in  1  1 = auto-retry allowed
host_clr  in  1  single-cycle host clear pulse
trip_out  out  1  1 = block power stage
reset_unit  out  1  clear pulse to detectors
fault_latch  out  N_FAULT  sticky history of unmasked faults
first_id  out  ID_W  index of first fault since last clear
first_valid  out  1  first_id is valid
retry_cnt  out  3  retries used
lockout  out  1  1 = in LOCK
state_o  out  3  current state encoding

Behaviour:
- Reset: state RUN; all outputs 0; counters 0.
- Tick: time_1us goes through a 2-FF sync; one tick event per synchronized high-to-low edge (sync == 2'b10).
- act = fault_in & ~fault_mask; any_f = |act.
- States: RUN=0, TRIP=1, COOL=2, CLR=3, CHECK=4, LOCK=5. All outputs and state are registered.
- RUN, trip_out=0: if any_f, go to TRIP and set trip_out=1 on the same edge (1 clk latency from fault_in).
  - fault_latch |= act.
  - If first_valid=0: first_id = lowest set index of act, first_valid=1.
- TRIP, one cycle: if retry_en && retry_cnt<MAX_RETRY go to COOL with the tick counter cleared; else go to LOCK with lockout=1.
- COOL: count ticks. On the COOL_US-th tick go to CLR and increment retry_cnt. New faults here only OR into fault_latch.
- CLR: reset_unit=1 for exactly RST_PULSE_CLK cycles, then go to CHECK with the tick counter cleared. Faults are ignored during CLR and the following clk cycle.
- CHECK, trip_out still 1:
  - any_f: go to TRIP and update fault_latch; first_id is unchanged.
  - CHECK_US ticks with no fault: go to RUN with trip_out=0.
  - retry_cnt is kept.
- LOCK: trip_out=1, lockout=1. On host_clr, clear retry_cnt, fault_latch and first_valid, set lockout=0, go to CLR. The CLR/CHECK sequence follows.
- host_clr in RUN: clear fault_latch, first_valid and retry_cnt. If any_f in the same cycle, the fault wins: go to TRIP; latch = act only; first_id is taken from act.
- host_clr in TRIP/COOL/CLR/CHECK: ignored.
- retry_cnt: saturating 3-bit; never exceeds MAX_RETRY.
- Tick counters: 16-bit, cleared on every state entry.
- Mask change: takes effect next cycle; it never clears fault_latch.
- rst_n mid-sequence: immediate return to reset values; any reset_unit pulse in progress is aborted.

Decomposition:
- Package: state encodings, STATE_W=3, and a lowest-set-index function used for first_id.
- Sub-module: tick_edge_sync, holding the 2-FF time_1us synchronizer and falling-edge pulse. It is reusable by the detectors.
- Everything else stays in one module.

Test Plan (COOL_US=10, CHECK_US=5, RST_PULSE_CLK=4, MAX_RETRY=3, 1 us = 50 clk):
1. fault_in=8'h04 pulse, cleared by reset_unit -> trip_out=1 after 1 clk; first_id=2; COOL 10 ticks; reset_unit high 4 clk; retry_cnt=1; after 5 clean ticks state=RUN and trip_out=0.
2. fault_in[5] stuck high, retry_en=1 -> 3 reset_unit pulses, retry_cnt=3, then lockout=1, state=5; trip_out stays 1 throughout.
3. From LOCK, host_clr pulse with fault removed -> retry_cnt=0, fault_latch=0, first_valid=0, 4-clk reset_unit, then RUN after 5 ticks.
4. fault_mask=8'h01, fault_in=8'h01 -> state stays RUN, trip_out=0, fault_latch=0; then fault_in=8'h81 -> trip, first_id=7.
5. fault_in=8'h18 in the same cycle -> first_id=3, fault_latch=8'h18. host_clr plus fault 8'h40 in the same RUN cycle -> TRIP, fault_latch=8'h40, first_id=6.
6. rst_n low during COOL tick 5 -> all outputs 0 immediately; after release with no fault, state=RUN and no reset_unit pulse.

Source files
------------

// File: rtl/fault_trip_manager_pkg.sv
// Shared state encodings and helpers for the fault trip manager.
package fault_trip_manager_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN   = 3'd0,
    ST_TRIP  = 3'd1,
    ST_COOL  = 3'd2,
    ST_CLR   = 3'd3,
    ST_CHECK = 3'd4,
    ST_LOCK  = 3'd5
  } state_t;

  // Index of the lowest set bit; callers only use it when at least one bit is set.
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    lowest_set = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) lowest_set = 5'(i);
    end
  endfunction

endpackage

// File: rtl/fault_trip_manager_tick_sync.sv
// Two-flop synchronizer for the 1 us timebase with a one-cycle pulse on each
// synchronized falling edge.
module tick_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic tick_o
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], async_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  // sync_q[1] is the older sample: 2'b10 means high then low.
  assign tick_o = (sync_q == 2'b10);

endmodule

// File: rtl/fault_trip_manager.sv
// Collects latched detector faults, blocks the power stage, and runs a timed
// auto-retry sequence that ends in a host-cleared lockout.
//
// state | meaning
// RUN   | normal operation, power stage enabled
// TRIP  | one-cycle decision: retry or lock out
// COOL  | waiting COOL_US ticks before a retry
// CLR   | pulsing reset_unit into the detectors
// CHECK | clean-run window after a retry
// LOCK  | retries exhausted or disabled, waiting for host_clr
module fault_trip_manager
  import fault_trip_manager_pkg::*;
#(
  parameter int N_FAULT       = 8,
  parameter int ID_W          = 3,
  parameter int COOL_US       = 1000,
  parameter int CHECK_US      = 100,
  parameter int RST_PULSE_CLK = 4,
  parameter int MAX_RETRY     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               time_1us,
  input  logic [N_FAULT-1:0] fault_in,
  input  logic [N_FAULT-1:0] fault_mask,
  input  logic               retry_en,
  input  logic               host_clr,
  output logic               trip_out,
  output logic               reset_unit,
  output logic [N_FAULT-1:0] fault_latch,
  output logic [ID_W-1:0]    first_id,
  output logic               first_valid,
  output logic [2:0]         retry_cnt,
  output logic               lockout,
  output logic [STATE_W-1:0] state_o
);

  state_t             state_q, state_d;
  logic               trip_q, trip_d;
  logic               reset_unit_q, reset_unit_d;
  logic [N_FAULT-1:0] latch_q, latch_d;
  logic [ID_W-1:0]    first_id_q, first_id_d;
  logic               first_valid_q, first_valid_d;
  logic [2:0]         retry_q, retry_d;
  logic               lockout_q, lockout_d;
  logic [15:0]        tick_cnt_q, tick_cnt_d;
  logic [15:0]        pulse_cnt_q, pulse_cnt_d;
  logic               ign_q, ign_d;

  logic               tick;
  logic [N_FAULT-1:0] act;
  logic               any_f;

  tick_edge_sync u_tick_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (time_1us),
    .tick_o   (tick)
  );

  assign act   = fault_in & ~fault_mask;
  assign any_f = |act;

  always_comb begin
    state_d       = state_q;
    trip_d        = trip_q;
    reset_unit_d  = reset_unit_q;
    latch_d       = latch_q;
    first_id_d    = first_id_q;
    first_valid_d = first_valid_q;
    retry_d       = retry_q;
    lockout_d     = lockout_q;
    tick_cnt_d    = tick_cnt_q;
    pulse_cnt_d   = pulse_cnt_q;
    ign_d         = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (host_clr) begin
          latch_d       = '0;
          first_valid_d = 1'b0;
          retry_d       = '0;
        end
        // A fault in the same cycle as host_clr wins, starting from the cleared history.
        if (any_f) begin
          state_d = ST_TRIP;
          trip_d  = 1'b1;
          latch_d = latch_d | act;
          if (!first_valid_d) begin
            first_id_d    = ID_W'(lowest_set(32'(act)));
            first_valid_d = 1'b1;
          end
        end
      end

      ST_TRIP: begin
        latch_d = latch_q | act;
        if (retry_en && (retry_q < 3'(MAX_RETRY))) begin
          state_d = ST_COOL;
        end else begin
          state_d   = ST_LOCK;
          lockout_d = 1'b1;
        end
      end

      ST_COOL: begin
        latch_d = latch_q | act;
        if (tick) begin
          if (tick_cnt_q == 16'(COOL_US - 1)) begin
            state_d      = ST_CLR;
            reset_unit_d = 1'b1;
            pulse_cnt_d  = 16'(RST_PULSE_CLK - 1);
            if (retry_q < 3'(MAX_RETRY)) retry_d = retry_q + 3'd1;
          end else begin
            tick_cnt_d = tick_cnt_q + 16'd1;
          end
        end
      end

      ST_CLR: begin
        if (pulse_cnt_q == 16'd0) begin
          state_d      = ST_CHECK;
          reset_unit_d = 1'b0;
          ign_d        = 1'b1;
        end else begin
          pulse_cnt_d = pulse_cnt_q - 16'd1;
        end
      end

      ST_CHECK: begin
        // Detectors may still be settling in the first cycle after the reset pulse.
        if (any_f && !ign_q) begin
          state_d = ST_TRIP;
          latch_d = latch_q | act;
        end else if (tick) begin
          if (tick_cnt_q == 16'(CHECK_US - 1)) begin
            state_d = ST_RUN;
            trip_d  = 1'b0;
          end else begin
            tick_cnt_d = tick_cnt_q + 16'd1;
          end
        end
      end

      ST_LOCK: begin
        trip_d    = 1'b1;
        lockout_d = 1'b1;
        latch_d   = latch_q | act;
        if (host_clr) begin
          state_d       = ST_CLR;
          retry_d       = '0;
          latch_d       = '0;
          first_valid_d = 1'b0;
          lockout_d     = 1'b0;
          reset_unit_d  = 1'b1;
          pulse_cnt_d   = 16'(RST_PULSE_CLK - 1);
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (state_d != state_q) tick_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      trip_q        <= 1'b0;
      reset_unit_q  <= 1'b0;
      latch_q       <= '0;
      first_id_q    <= '0;
      first_valid_q <= 1'b0;
      retry_q       <= '0;
      lockout_q     <= 1'b0;
      tick_cnt_q    <= '0;
      pulse_cnt_q   <= '0;
      ign_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      trip_q        <= trip_d;
      reset_unit_q  <= reset_unit_d;
      latch_q       <= latch_d;
      first_id_q    <= first_id_d;
      first_valid_q <= first_valid_d;
      retry_q       <= retry_d;
      lockout_q     <= lockout_d;
      tick_cnt_q    <= tick_cnt_d;
      pulse_cnt_q   <= pulse_cnt_d;
      ign_q         <= ign_d;
    end
  end

  assign trip_out    = trip_q;
  assign reset_unit  = reset_unit_q;
  assign fault_latch = latch_q;
  assign first_id    = first_id_q;
  assign first_valid = first_valid_q;
  assign retry_cnt   = retry_q;
  assign lockout     = lockout_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_fault_trip_manager.sv
// Scoreboard bench: expected state visits are queued by the stimulus and
// checked by a monitor on every state change of the DUT.
module tb_fault_trip_manager;

  localparam int COOL = 10;
  localparam int CHK  = 5;
  localparam int RSTP = 4;
  localparam int TPER = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       time_1us = 1'b0;
  logic [7:0] fault_in = 8'h00;
  logic [7:0] fault_mask = 8'h00;
  logic       retry_en = 1'b1;
  logic       host_clr = 1'b0;
  logic       trip_out;
  logic       reset_unit;
  logic [7:0] fault_latch;
  logic [2:0] first_id;
  logic       first_valid;
  logic [2:0] retry_cnt;
  logic       lockout;
  logic [2:0] state_o;

  fault_trip_manager #(
    .N_FAULT(8), .ID_W(3), .COOL_US(COOL), .CHECK_US(CHK),
    .RST_PULSE_CLK(RSTP), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .time_1us(time_1us), .fault_in(fault_in),
    .fault_mask(fault_mask), .retry_en(retry_en), .host_clr(host_clr),
    .trip_out(trip_out), .reset_unit(reset_unit), .fault_latch(fault_latch),
    .first_id(first_id), .first_valid(first_valid), .retry_cnt(retry_cnt),
    .lockout(lockout), .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2;
    forever #250 time_1us = ~time_1us;
  end

  typedef struct packed {
    logic [2:0] st;
    logic       trip;
    logic       lock;
    logic [2:0] rc;
    logic       fv;
    logic [2:0] id;
    logic [7:0] latch;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push(input int st, input int trip, input int lock, input int rc,
                      input int fv, input int id, input int latch);
    exp_t e;
    e.st = 3'(st); e.trip = 1'(trip); e.lock = 1'(lock); e.rc = 3'(rc);
    e.fv = 1'(fv); e.id = 3'(id); e.latch = 8'(latch);
    sbq.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    int n = 0;
    while (state_o !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(state_o), 32'(s));
  endtask

  task automatic wait_ru(input int budget, input string nm);
    int n = 0;
    while (reset_unit !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(reset_unit), 32'd1);
  endtask

  task automatic host_pulse();
    @(negedge clk);
    host_clr = 1'b1;
    @(negedge clk);
    host_clr = 1'b0;
  endtask

  // Monitor: reset_unit width, state dwell times, and per-transition outputs.
  logic [2:0] mon_prev = 3'd0;
  int         dur = 0;
  int         ru_w = 0;

  always @(negedge clk) begin
    exp_t e;
    if (reset_unit === 1'b1) begin
      ru_w++;
    end else if (ru_w != 0) begin
      tests++;
      if (ru_w != RSTP) begin
        fails++;
        $display("FAIL reset_unit_width got %0d want %0d", ru_w, RSTP);
      end
      ru_w = 0;
    end
    if (state_o !== mon_prev) begin
      if (mon_prev == 3'd2 && state_o == 3'd3) begin
        tests++;
        if (dur < (COOL - 1) * TPER || dur > COOL * TPER + 1) begin
          fails++;
          $display("FAIL cool_len got %0d clk want %0d..%0d", dur, (COOL - 1) * TPER, COOL * TPER + 1);
        end
      end
      if (mon_prev == 3'd4 && state_o == 3'd0 && rst_n) begin
        tests++;
        if (dur < (CHK - 1) * TPER || dur > CHK * TPER + 1) begin
          fails++;
          $display("FAIL check_len got %0d clk want %0d..%0d", dur, (CHK - 1) * TPER, CHK * TPER + 1);
        end
      end
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_transition got state %0d from %0d want none", state_o, mon_prev);
      end else begin
        e = sbq.pop_front();
        if (e.st !== state_o || e.trip !== trip_out || e.lock !== lockout ||
            e.rc !== retry_cnt || e.fv !== first_valid ||
            (e.fv && e.id !== first_id) || e.latch !== fault_latch) begin
          fails++;
          $display("FAIL transition got st=%0d trip=%0b lock=%0b rc=%0d fv=%0b id=%0d latch=%02h want st=%0d trip=%0b lock=%0b rc=%0d fv=%0b id=%0d latch=%02h",
                   state_o, trip_out, lockout, retry_cnt, first_valid, first_id, fault_latch,
                   e.st, e.trip, e.lock, e.rc, e.fv, e.id, e.latch);
        end
      end
      dur = 1;
      mon_prev = state_o;
    end else begin
      dur++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_outs", 32'({trip_out, reset_unit, lockout, first_valid, retry_cnt, fault_latch}), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: single fault, detector cleared by the reset pulse, successful retry
    push(1, 1, 0, 0, 1, 2, 8'h04);
    push(2, 1, 0, 0, 1, 2, 8'h04);
    push(3, 1, 0, 1, 1, 2, 8'h04);
    push(4, 1, 0, 1, 1, 2, 8'h04);
    push(0, 0, 0, 1, 1, 2, 8'h04);
    fault_in = 8'h04;
    @(posedge clk);
    #1 chk("t1_latency", 32'(trip_out), 32'd1);
    wait_ru(800, "t1_reset_unit");
    fault_in = 8'h00;
    wait_state(3'd0, 600, "t1_run");

    // 2: stuck fault exhausts the retries
    host_pulse();
    for (int r = 0; r < 3; r++) begin
      push(1, 1, 0, r, 1, 5, 8'h20);
      push(2, 1, 0, r, 1, 5, 8'h20);
      push(3, 1, 0, r + 1, 1, 5, 8'h20);
      push(4, 1, 0, r + 1, 1, 5, 8'h20);
    end
    push(1, 1, 0, 3, 1, 5, 8'h20);
    push(5, 1, 1, 3, 1, 5, 8'h20);
    fault_in = 8'h20;
    wait_state(3'd5, 3000, "t2_lock");
    chk("t2_lock_outs", 32'({trip_out, lockout}), 32'd3);

    // 3: host clear from lockout
    fault_in = 8'h00;
    push(3, 1, 0, 0, 0, 0, 8'h00);
    push(4, 1, 0, 0, 0, 0, 8'h00);
    push(0, 0, 0, 0, 0, 0, 8'h00);
    host_pulse();
    wait_state(3'd0, 600, "t3_run");

    // 4: masked channel ignored, then highest channel trips
    fault_mask = 8'h01;
    fault_in = 8'h01;
    repeat (20) @(negedge clk);
    chk("t4_masked", 32'({state_o, trip_out, fault_latch}), 32'd0);
    push(1, 1, 0, 0, 1, 7, 8'h80);
    push(2, 1, 0, 0, 1, 7, 8'h80);
    push(3, 1, 0, 1, 1, 7, 8'h80);
    push(4, 1, 0, 1, 1, 7, 8'h80);
    push(0, 0, 0, 1, 1, 7, 8'h80);
    fault_in = 8'h81;
    wait_ru(800, "t4_reset_unit");
    fault_in = 8'h00;
    fault_mask = 8'h00;
    wait_state(3'd0, 600, "t4_run");

    // 5: simultaneous faults, then host_clr and fault in the same cycle
    host_pulse();
    push(1, 1, 0, 0, 1, 3, 8'h18);
    push(2, 1, 0, 0, 1, 3, 8'h18);
    push(3, 1, 0, 1, 1, 3, 8'h18);
    push(4, 1, 0, 1, 1, 3, 8'h18);
    push(0, 0, 0, 1, 1, 3, 8'h18);
    fault_in = 8'h18;
    wait_ru(800, "t5a_reset_unit");
    fault_in = 8'h00;
    wait_state(3'd0, 600, "t5a_run");
    push(1, 1, 0, 0, 1, 6, 8'h40);
    push(2, 1, 0, 0, 1, 6, 8'h40);
    push(3, 1, 0, 1, 1, 6, 8'h40);
    push(4, 1, 0, 1, 1, 6, 8'h40);
    push(0, 0, 0, 1, 1, 6, 8'h40);
    @(negedge clk);
    host_clr = 1'b1;
    fault_in = 8'h40;
    @(negedge clk);
    host_clr = 1'b0;
    wait_ru(800, "t5b_reset_unit");
    fault_in = 8'h00;
    wait_state(3'd0, 600, "t5b_run");

    // 6: asynchronous reset in the middle of COOL
    push(1, 1, 0, 1, 1, 6, 8'h44);
    push(2, 1, 0, 1, 1, 6, 8'h44);
    push(0, 0, 0, 0, 0, 0, 8'h00);
    fault_in = 8'h04;
    wait_state(3'd2, 20, "t6_cool");
    fault_in = 8'h00;
    repeat (225) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_reset",
           32'({state_o, trip_out, reset_unit, lockout, first_valid, retry_cnt, fault_latch}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (reset_unit === 1'b1) seen++;
    end
    chk("t6_no_pulse", 32'(seen), 32'd0);
    chk("t6_run", 32'({state_o, trip_out}), 32'd0);

    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
